// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl
// Purpose  : NUM_SRC-source 68000 interrupt controller. Per-source enable,
//            edge/level mode and priority level; drives IPL, resolves
//            acknowledge cycles into vectors, CPU-mapped register bank.
// Options  : IRQ_CTRL_INPUT_SYNC_EN - two-flop synchronizer on every src bit.
// Revision : 1.0 - initial release
// ============================================================================
module irq_ctrl #(
  parameter int       NUM_SRC      = 7,
  parameter bit [7:0] VECTOR_BASE  = 8'h40,
  parameter bit [7:0] SPURIOUS_VEC = 8'h18
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  input  logic               cs,
  input  logic [1:0]         wr,
  input  logic [3:0]         address,
  input  logic [15:0]        din,
  output logic [15:0]        dout,
  input  logic               iack,
  input  logic [2:0]         ack_level,
  output logic [2:0]         ipl_n,
  output logic [7:0]         vector,
  output logic               spurious
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACK = 1'b1} state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_SRC-1:0] w_src, r_src_prev;
  logic [NUM_SRC-1:0] r_pending, r_enable, r_mode;
  logic [NUM_SRC-1:0] w_pend_nxt, w_enable_nxt, w_mode_nxt;
  logic [2:0]         r_level     [NUM_SRC];
  logic [2:0]         w_level_nxt [NUM_SRC];
  logic [15:0]        w_lvl_rd    [4];
  logic [15:0]        w_bmask;
  logic               r_iack_prev, w_iack_rise, w_ack_take, w_ack_hit;
  logic [3:0]         w_ack_idx, r_last_src;
  logic [2:0]         w_win_lvl, r_ipl_n, w_ipl_nxt;
  logic [7:0]         r_vector;
  logic               r_spurious;
  logic               w_unused;

`ifdef IRQ_CTRL_INPUT_SYNC_EN
  logic [NUM_SRC-1:0] r_sync1, r_sync2;
  // Two-flop synchronizer; loads src in reset so a held-high input gives no edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= src;
      r_sync2 <= src;
    end else begin
      r_sync1 <= src;
      r_sync2 <= r_sync1;
    end
  end
  assign w_src = r_sync2;
`else
  assign w_src = src;
`endif

  assign w_bmask     = {{8{wr[1]}}, {8{wr[0]}}};
  assign w_iack_rise = iack & ~r_iack_prev;
  assign w_unused    = &{1'b0, din, w_bmask};

  // Per-source next-state of pending, enable, mode and level registers.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      localparam logic [3:0] c_word = 4'(4 + gi / 4);
      localparam int         c_lane = gi % 4;
      logic w_w1c, w_clr, w_edge;
      assign w_w1c  = cs & (address == 4'd0) & w_bmask[gi] & din[gi];
      assign w_clr  = w_w1c | (w_ack_take & w_ack_hit & (w_ack_idx == 4'(gi)));
      assign w_edge = w_src[gi] & ~r_src_prev[gi];
      // A fresh edge outranks any clear in the same cycle.
      assign w_pend_nxt[gi] = r_mode[gi] ? w_src[gi]
                                         : (w_edge | (r_pending[gi] & ~w_clr));
      assign w_enable_nxt[gi] = (cs && address == 4'd1 && w_bmask[gi]) ? din[gi] : r_enable[gi];
      assign w_mode_nxt[gi]   = (cs && address == 4'd2 && w_bmask[gi]) ? din[gi] : r_mode[gi];
      assign w_level_nxt[gi]  = (cs && address == c_word && w_bmask[4*c_lane])
                                ? din[4*c_lane +: 3] : r_level[gi];
    end
  endgenerate

  // Level read-back words: four 4-bit lanes per word, missing sources read 0.
  genvar gk, gj;
  generate
    for (gk = 0; gk < 4; gk++) begin : g_lw
      for (gj = 0; gj < 4; gj++) begin : g_lane
        if (4*gk + gj < NUM_SRC) begin : g_used
          assign w_lvl_rd[gk][4*gj +: 4] = {1'b0, r_level[4*gk + gj]};
        end else begin : g_empty
          assign w_lvl_rd[gk][4*gj +: 4] = 4'b0;
        end
      end
    end
  endgenerate

  // Arbitration: highest level among pending & enabled; strict > keeps lowest index on ties.
  always_comb begin
    w_win_lvl = 3'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_pending[i] && r_enable[i] && (r_level[i] > w_win_lvl)) w_win_lvl = r_level[i];
    end
  end

  // Acknowledge match: lowest-index pending & enabled source at the acknowledged level.
  always_comb begin
    w_ack_hit = 1'b0;
    w_ack_idx = 4'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (r_pending[i] && r_enable[i] && (r_level[i] != 3'd0) && (r_level[i] == ack_level)) begin
        w_ack_hit = 1'b1;
        w_ack_idx = 4'(i);
      end
    end
  end

  // State register and all per-source registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_src_prev  <= w_src;
      r_iack_prev <= iack;
      r_pending   <= '0;
      r_enable    <= '0;
      r_mode      <= '0;
      for (int i = 0; i < NUM_SRC; i++) r_level[i] <= 3'd0;
      r_ipl_n     <= 3'b111;
      r_vector    <= 8'd0;
      r_spurious  <= 1'b0;
      r_last_src  <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_src_prev  <= w_src;
      r_iack_prev <= iack;
      r_pending   <= w_pend_nxt;
      r_enable    <= w_enable_nxt;
      r_mode      <= w_mode_nxt;
      r_level     <= w_level_nxt;
      r_ipl_n     <= w_ipl_nxt;
      if (w_ack_take) begin
        if (w_ack_hit) begin
          r_vector   <= VECTOR_BASE + {4'd0, w_ack_idx};
          r_spurious <= 1'b0;
          r_last_src <= w_ack_idx;
        end else begin
          r_vector   <= SPURIOUS_VEC;
          r_spurious <= 1'b1;
        end
      end
    end
  end

  // Next state: ACK on an iack rise, back to IDLE once iack drops; IPL forced off in ACK.
  always_comb begin
    w_state_nxt = r_state;
    w_ack_take  = 1'b0;
    case (r_state)
      S_IDLE: if (w_iack_rise) begin
        w_state_nxt = S_ACK;
        w_ack_take  = 1'b1;
      end
      S_ACK:   if (!iack) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_ipl_nxt = (w_state_nxt == S_ACK) ? 3'b111 : ~w_win_lvl;
  end

  // Zero-latency register read mux.
  always_comb begin
    dout = 16'd0;
    case (address)
      4'd0:    dout[NUM_SRC-1:0] = r_pending;
      4'd1:    dout[NUM_SRC-1:0] = r_enable;
      4'd2:    dout[NUM_SRC-1:0] = r_mode;
      4'd3:    dout = {7'd0, r_spurious, r_last_src, 1'b0, ~r_ipl_n};
      4'd4, 4'd5, 4'd6, 4'd7: dout = w_lvl_rd[address[1:0]];
      default: dout = 16'd0;
    endcase
  end

  assign ipl_n    = r_ipl_n;
  assign vector   = r_vector;
  assign spurious = r_spurious;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_ctrl
// Purpose  : Directed scoreboard bench for irq_ctrl (default 7 sources).
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;

`ifdef IRQ_CTRL_INPUT_SYNC_EN
  localparam int c_lat = 4;
`else
  localparam int c_lat = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  src;
  logic        cs;
  logic [1:0]  wr;
  logic [3:0]  address;
  logic [15:0] din;
  logic [15:0] dout;
  logic        iack;
  logic [2:0]  ack_level;
  logic [2:0]  ipl_n;
  logic [7:0]  vector;
  logic        spurious;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  string       tag_q[$];

  irq_ctrl dut (
    .clk(clk), .reset(reset), .src(src), .cs(cs), .wr(wr), .address(address),
    .din(din), .dout(dout), .iack(iack), .ack_level(ack_level),
    .ipl_n(ipl_n), .vector(vector), .spurious(spurious)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string tag, input logic [15:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic chk(input logic [15:0] obs);
    logic [15:0] e;
    string       t;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [15:0] d);
    cs = 1'b1; wr = 2'b11; address = a; din = d;
    tick();
    cs = 1'b0; wr = 2'b00;
  endtask

  task automatic rdchk(input logic [3:0] a);
    address = a;
    #1;
    chk(dout);
  endtask

  task automatic chk_ipl();  chk({13'd0, ipl_n});    endtask
  task automatic chk_vec();  chk({8'd0, vector});    endtask
  task automatic chk_spur(); chk({15'd0, spurious}); endtask

  initial begin
    reset = 1'b1; src = '0; cs = 1'b0; wr = 2'b00; address = 4'd0;
    din = 16'd0; iack = 1'b0; ack_level = 3'd0;
    tick(); tick();
    reset = 1'b0;
    tick();
    expect_v("rst_ipl", 16'h0007);     chk_ipl();
    expect_v("rst_vec", 16'h0000);     chk_vec();
    expect_v("rst_spur", 16'h0000);    chk_spur();
    expect_v("rst_pending", 16'h0000); rdchk(4'd0);
    expect_v("rst_status", 16'h0000);  rdchk(4'd3);

    // Edge source 2 at level 5.
    wr_reg(4'd4, 16'h0500);
    wr_reg(4'd1, 16'h0004);
    src = 7'h04;
    tick();
    expect_v("t1_pending_set", 16'h0004); rdchk(4'd0);
    expect_v("t1_ipl_not_yet", 16'h0007); chk_ipl();
    src = 7'h00;
    tick();
    expect_v("t1_ipl_lvl5", 16'h0002); chk_ipl();
    ack_level = 3'd5; iack = 1'b1;
    tick();
    expect_v("t1_vec", 16'h0042);         chk_vec();
    expect_v("t1_spur", 16'h0000);        chk_spur();
    expect_v("t1_ipl_ack", 16'h0007);     chk_ipl();
    expect_v("t1_pending_clr", 16'h0000); rdchk(4'd0);
    expect_v("t1_status", 16'h0020);      rdchk(4'd3);
    iack = 1'b0;
    tick();
    expect_v("t1_ipl_after", 16'h0007); chk_ipl();

    // Sources 0 and 3 tied at level 4.
    wr_reg(4'd4, 16'h4004);
    wr_reg(4'd1, 16'h0009);
    src = 7'h09; tick();
    src = 7'h00; tick();
    expect_v("t2_ipl_lvl4", 16'h0003); chk_ipl();
    ack_level = 3'd4; iack = 1'b1;
    tick();
    expect_v("t2_vec_first", 16'h0040);  chk_vec();
    expect_v("t2_pending_1", 16'h0008);  rdchk(4'd0);
    iack = 1'b0;
    tick();
    expect_v("t2_ipl_reassert", 16'h0003); chk_ipl();
    iack = 1'b1;
    tick();
    expect_v("t2_vec_second", 16'h0043); chk_vec();
    expect_v("t2_pending_2", 16'h0000);  rdchk(4'd0);
    iack = 1'b0;
    tick();
    expect_v("t2_ipl_idle", 16'h0007); chk_ipl();

    // Level-mode source 1 at level 2, held high.
    wr_reg(4'd2, 16'h0002);
    wr_reg(4'd4, 16'h4024);
    wr_reg(4'd1, 16'h000B);
    src = 7'h02; tick(); tick();
    expect_v("t3_ipl_lvl2", 16'h0005); chk_ipl();
    ack_level = 3'd2; iack = 1'b1;
    tick();
    expect_v("t3_vec", 16'h0041);    chk_vec();
    expect_v("t3_ipl_ack", 16'h0007); chk_ipl();
    wr_reg(4'd0, 16'h0002);
    expect_v("t3_pending_held", 16'h0002); rdchk(4'd0);
    iack = 1'b0;
    tick();
    expect_v("t3_ipl_reassert", 16'h0005); chk_ipl();
    src = 7'h00;
    tick();
    expect_v("t3_pending_follow", 16'h0000); rdchk(4'd0);
    tick();
    expect_v("t3_ipl_idle", 16'h0007); chk_ipl();

    // Spurious acknowledge: only a level-3 source pending, ack at 6.
    wr_reg(4'd2, 16'h0000);
    wr_reg(4'd4, 16'h3000);
    src = 7'h08; tick();
    src = 7'h00; tick();
    expect_v("t4_ipl_lvl3", 16'h0004); chk_ipl();
    ack_level = 3'd6; iack = 1'b1;
    tick();
    expect_v("t4_vec", 16'h0018);     chk_vec();
    expect_v("t4_spur", 16'h0001);    chk_spur();
    expect_v("t4_status", 16'h0110);  rdchk(4'd3);
    expect_v("t4_pending", 16'h0008); rdchk(4'd0);
    iack = 1'b0;
    tick();
    expect_v("t4_ipl_after", 16'h0004); chk_ipl();
    wr_reg(4'd0, 16'h0008);
    expect_v("t4_w1c", 16'h0000); rdchk(4'd0);

    // Edge and W1C on the same bit in the same cycle: set wins.
    src = 7'h01; tick();
    src = 7'h00; tick();
    expect_v("t5_pending_pre", 16'h0001); rdchk(4'd0);
    src = 7'h01;
    cs = 1'b1; wr = 2'b11; address = 4'd0; din = 16'h0001;
    tick();
    cs = 1'b0; wr = 2'b00;
    expect_v("t5_set_wins", 16'h0001); rdchk(4'd0);
    src = 7'h00;
    wr_reg(4'd0, 16'h0001);
    expect_v("t5_w1c_alone", 16'h0000); rdchk(4'd0);

    // Reset mid-acknowledge with src[4] and iack held high across reset.
    ack_level = 3'd7; iack = 1'b1;
    tick();
    src = 7'h10; reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    expect_v("t6_pending", 16'h0000); rdchk(4'd0);
    expect_v("t6_enable", 16'h0000);  rdchk(4'd1);
    expect_v("t6_vec", 16'h0000);     chk_vec();
    expect_v("t6_ipl", 16'h0007);     chk_ipl();
    wr_reg(4'd5, 16'h0007);
    wr_reg(4'd1, 16'h0010);
    src = 7'h00;
    tick(); tick(); tick();
    src = 7'h10;
    repeat (c_lat - 1) tick();
    expect_v("t6_ipl_early", 16'h0007); chk_ipl();
    tick();
    expect_v("t6_ipl_lat", 16'h0000); chk_ipl();
    expect_v("t6_vec_ignored", 16'h0000); chk_vec();
    iack = 1'b0; tick();
    iack = 1'b1; tick();
    expect_v("t6_vec_reack", 16'h0044); chk_vec();
    expect_v("t6_ipl_ack", 16'h0007);   chk_ipl();
    iack = 1'b0; tick();

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
